// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int frame_bits(input int data_bits, input int parity_mode,
                                      input int stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous fall-through FIFO feeding the UART transmitter; DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      level <= level + LW'(1);
            else if (!push_ok && pop_ok) level <= level - LW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (data width, parity, stop bits).
// Define UART_TX_FIFO_EN to insert an input FIFO for gap-free back-to-back frames.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_BITS-1:0]            in_byte,
    output logic                            serial_out,
    output logic                            busy,
    output logic                            r_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_BITS - 1);
    localparam logic [0:0]    LAST_STOP  = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        bit_idx, idx_n;
    logic [0:0]           stop_cnt, stop_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 par_bit, par_n;
    logic                 serial_n, busy_n, done_n;
    logic                 load;
    logic                 word_avail;
    logic [DATA_BITS-1:0] word;
    logic                 tc;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (in_byte),
        .pop       (load),
        .pop_data  (word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready   = !fifo_full;
    assign word_avail = !fifo_empty;
`else
    // Without the FIFO the word is loaded straight from the input on the accept edge.
    assign in_ready   = (state == IDLE);
    assign word_avail = in_valid && in_ready;
    assign word       = in_byte;
    assign fifo_level = '0;
`endif

    assign tc = (cnt == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_cnt   <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= idx_n;
            stop_cnt   <= stop_n;
            shift_reg  <= shift_n;
            par_bit    <= par_n;
            serial_out <= serial_n;
            busy       <= busy_n;
            r_done     <= done_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = bit_idx;
        stop_n   = stop_cnt;
        shift_n  = shift_reg;
        par_n    = par_bit;
        serial_n = serial_out;
        busy_n   = busy;
        done_n   = 1'b0;
        load     = 1'b0;

        case (state)
            IDLE: load = word_avail;
            START: begin
                if (tc) begin
                    state_n  = DATA;
                    cnt_n    = CNT_RELOAD;
                    idx_n    = '0;
                    serial_n = shift_reg[0];
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DATA: begin
                if (tc) begin
                    cnt_n = CNT_RELOAD;
                    if (bit_idx == LAST_IDX) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            state_n  = PARITY;
                            serial_n = par_bit;
                        end else begin
                            state_n  = STOP;
                            stop_n   = '0;
                            serial_n = 1'b1;
                        end
                    end else begin
                        idx_n    = bit_idx + IW'(1);
                        shift_n  = shift_reg >> 1;
                        serial_n = shift_reg[1];
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PARITY: begin
                if (tc) begin
                    state_n  = STOP;
                    cnt_n    = CNT_RELOAD;
                    stop_n   = '0;
                    serial_n = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            STOP: begin
                if (tc) begin
                    if (stop_cnt == LAST_STOP) begin
                        done_n = 1'b1;
                        if (word_avail) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                        cnt_n  = CNT_RELOAD;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // A load starts the start bit on this edge; parity is fixed here from the loaded word.
        if (load) begin
            state_n  = START;
            cnt_n    = CNT_RELOAD;
            idx_n    = '0;
            stop_n   = '0;
            shift_n  = word;
            par_n    = (^word) ^ (PARITY_MODE == PAR_ODD);
            serial_n = 1'b0;
            busy_n   = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param: 8N1, 7O2 and 8E1 instances at 4 clocks per bit.
module tb_uart_tx_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v0, v1, v2;
    logic [7:0] b0;
    logic [6:0] b1;
    logic [7:0] b2;
    logic       r0, r1, r2;
    logic       s0, s1, s2;
    logic       y0, y1, y2;
    logic       d0, d1, d2;
    logic [2:0] l0, l1, l2;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic       mon_serial, mon_busy, mon_done, mon_ready;
    logic [2:0] mon_level;

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) u_8n1 (
        .clock(clk), .reset(rst_n), .in_valid(v0), .in_ready(r0), .in_byte(b0),
        .serial_out(s0), .busy(y0), .r_done(d0), .fifo_level(l0));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                    .FIFO_DEPTH(4)) u_7o2 (
        .clock(clk), .reset(rst_n), .in_valid(v1), .in_ready(r1), .in_byte(b1),
        .serial_out(s1), .busy(y1), .r_done(d1), .fifo_level(l1));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) u_8e1 (
        .clock(clk), .reset(rst_n), .in_valid(v2), .in_ready(r2), .in_byte(b2),
        .serial_out(s2), .busy(y2), .r_done(d2), .fifo_level(l2));

    always_comb begin
        mon_serial = s0; mon_busy = y0; mon_done = d0; mon_ready = r0; mon_level = l0;
        case (sel)
            1: begin mon_serial = s1; mon_busy = y1; mon_done = d1; mon_ready = r1; mon_level = l1; end
            2: begin mon_serial = s2; mon_busy = y2; mon_done = d2; mon_ready = r2; mon_level = l2; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            1:       begin v1 = v; b1 = d[6:0]; end
            2:       begin v2 = v; b2 = d; end
            default: begin v0 = v; b0 = d; end
        endcase
    endtask

    // Returns just after the edge on which the start bit appears.
    task automatic start_frame(input int s, input logic [7:0] d);
        sel = s;
        @(negedge clk);
        drive(s, 1'b1, d);
        @(posedge clk);
        #1 drive(s, 1'b0, d);
`ifdef UART_TX_FIFO_EN
        @(posedge clk);
        #1;
`endif
    endtask

    // pat holds the line bits in transmit order; each must be held for exactly 4 cycles.
    task automatic check_frame(input string tag, input string pat);
        int n;
        n = pat.len() * 4;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s serial c%0d", tag, k), mon_serial, pat[k/4] == "1");
            check($sformatf("%s busy c%0d", tag, k), mon_busy, 1);
            check($sformatf("%s done c%0d", tag, k), mon_done, 0);
`ifndef UART_TX_FIFO_EN
            check($sformatf("%s ready c%0d", tag, k), mon_ready, 0);
`endif
        end
        @(negedge clk);
        check({tag, " done pulse"}, mon_done, 1);
        check({tag, " line idle"}, mon_serial, 1);
        check({tag, " busy low"}, mon_busy, 0);
    endtask

`ifdef UART_TX_FIFO_EN
    string      bw[5] = '{"0100000001", "0000000011", "0111111111", "0000000001", "0001111001"};
    logic [7:0] wv[5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C};
    int         lv_exp[5] = '{1, 1, 2, 3, 4};
    string      cur;
    int         kk;
    int         dones;
`endif

    initial begin
        v0 = 0; v1 = 0; v2 = 0; b0 = '0; b1 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check($sformatf("rst ready u%0d", s), mon_ready, 1);
            check($sformatf("rst serial u%0d", s), mon_serial, 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check($sformatf("post-rst serial u%0d", s), mon_serial, 1);
            check($sformatf("post-rst busy u%0d", s), mon_busy, 0);
            check($sformatf("post-rst done u%0d", s), mon_done, 0);
            check($sformatf("post-rst ready u%0d", s), mon_ready, 1);
            check($sformatf("post-rst level u%0d", s), mon_level, 0);
        end

        start_frame(0, 8'hA5); check_frame("8n1_a5", "0101001011");
        @(negedge clk); check("8n1_a5 done one cycle", mon_done, 0);
        start_frame(0, 8'h00); check_frame("8n1_00", "0000000001");
        start_frame(1, 8'h03); check_frame("7o2_03", "01100000111");
        start_frame(1, 8'h00); check_frame("7o2_00", "00000000111");
        start_frame(1, 8'h7F); check_frame("7o2_7f", "01111111011");
        start_frame(2, 8'hFF); check_frame("8e1_ff", "01111111101");
        start_frame(2, 8'h01); check_frame("8e1_01", "01000000011");
        @(negedge clk);

`ifndef UART_TX_FIFO_EN
        // in_valid held high across two words; in_byte changes right after the first accept.
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'hC3);
        @(posedge clk);
        #1 b0 = 8'h0F;
        check_frame("hold_c3", "0110000111");
        check("hold idle gap ready", mon_ready, 1);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h0F);
        check_frame("hold_0f", "0111100001");
        @(negedge clk); check("hold done one cycle", mon_done, 0);
`else
        // Five pushes on consecutive edges; frames must follow each other with no idle gap.
        sel   = 0;
        dones = 0;
        @(negedge clk);
        drive(0, 1'b1, wv[0]);
        for (int c = 0; c <= 202; c++) begin
            @(posedge clk);
            #1;
            if (c < 4) drive(0, 1'b1, wv[c+1]);
            else       drive(0, 1'b0, 8'h00);
            @(negedge clk);
            if (c <= 4) begin
                check($sformatf("burst level c%0d", c), mon_level, lv_exp[c]);
                check($sformatf("burst ready c%0d", c), mon_ready, (c == 4) ? 0 : 1);
            end
            if (c >= 1 && c <= 200) begin
                kk  = c - 1;
                cur = bw[kk/40];
                check($sformatf("burst serial c%0d", c), mon_serial, cur[(kk%40)/4] == "1");
            end
            check($sformatf("burst done c%0d", c), mon_done, (c >= 41 && (c - 1) % 40 == 0) ? 1 : 0);
            if (mon_done) dones++;
        end
        check("burst done count", dones, 5);
        check("burst level end", mon_level, 0);
        check("burst busy end", mon_busy, 0);
        check("burst serial end", mon_serial, 1);
`endif

        // Mid-frame reset: the line must go high immediately with no completion pulse.
        start_frame(0, 8'h55);
        repeat (10) @(negedge clk);
        check("pre-reset line low", mon_serial, 0);
        #2 rst_n = 1'b0;
        #1 check("mid-rst serial", mon_serial, 1);
        check("mid-rst busy", mon_busy, 0);
        check("mid-rst level", mon_level, 0);
        check("mid-rst ready", mon_ready, 1);
        check("mid-rst done", mon_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("after-rst done c%0d", i), mon_done, 0);
            check($sformatf("after-rst serial c%0d", i), mon_serial, 1);
            check($sformatf("after-rst busy c%0d", i), mon_busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
